// File: rtl/load_store_unit_if.sv
// Core-side request/response bus of the load/store unit.
// The core drives the request fields and the unit returns ready/done/err/rdata.
interface load_store_unit_if #(
    parameter int DEPTH = 8
) ();
    logic             req_i;
    logic             we_i;
    logic [2:0]       funct3_i;
    logic [DEPTH-1:0] addr_i;
    logic [31:0]      wdata_i;
    logic             ready_o;
    logic             done_o;
    logic             err_o;
    logic [31:0]      rdata_o;

    modport master (
        output req_i, we_i, funct3_i, addr_i, wdata_i,
        input  ready_o, done_o, err_o, rdata_o
    );

    modport slave (
        input  req_i, we_i, funct3_i, addr_i, wdata_i,
        output ready_o, done_o, err_o, rdata_o
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte/halfword/word load-store unit in front of a word-only data memory.
// Sub-word stores read the target word and write back a merged copy.
module load_store_unit #(
    parameter int DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    load_store_unit_if.slave     bus,
    output logic [DEPTH-1:0]     mem_rd_addr_o,
    input  logic [31:0]          mem_rd_data_i,
    output logic                 mem_write_o,
    output logic [DEPTH-1:0]     mem_wr_addr_o,
    output logic [31:0]          mem_wr_data_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ACCESS = 2'b01,
        S_RESP   = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic             we_q;
    logic [2:0]       funct3_q;
    logic [DEPTH-1:0] addr_q;
    logic [31:0]      wdata_q;
    logic             done_q;
    logic             err_q;
    logic [31:0]      rdata_q;

    logic             ready_s;
    logic             accept_s;
    logic             err_s;
    logic [31:0]      load_s;
    logic [31:0]      merge_s;

    // Illegal funct3 for the direction, or an address not aligned to the access size.
    function automatic logic access_error(input logic we, input logic [2:0] f3,
                                          input logic [1:0] lane);
        logic e;
        case (f3)
            3'b000:  e = 1'b0;
            3'b001:  e = lane[0];
            3'b010:  e = |lane;
            3'b100:  e = we;
            3'b101:  e = we | lane[0];
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] merge_store(input logic [2:0] f3, input logic [1:0] lane,
                                                input logic [31:0] old_word,
                                                input logic [31:0] wd);
        logic [31:0] r;
        r = old_word;
        case (f3[1:0])
            2'b00:   r[{lane, 3'b000} +: 8] = wd[7:0];
            2'b01:   r[{lane[1], 4'b0000} +: 16] = wd[15:0];
            default: r = wd;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extract_load(input logic [2:0] f3, input logic [1:0] lane,
                                                 input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] r;
        sh = word >> {lane, 3'b000};
        case (f3)
            3'b000:  r = {{24{sh[7]}}, sh[7:0]};
            3'b001:  r = {{16{sh[15]}}, sh[15:0]};
            3'b010:  r = word;
            3'b100:  r = {24'h000000, sh[7:0]};
            3'b101:  r = {16'h0000, sh[15:0]};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    assign ready_s  = (state_q != S_ACCESS);
    assign accept_s = bus.req_i & ready_s;
    assign err_s    = access_error(we_q, funct3_q, addr_q[1:0]);
    assign load_s   = extract_load(funct3_q, addr_q[1:0], mem_rd_data_i);
    assign merge_s  = merge_store(funct3_q, addr_q[1:0], mem_rd_data_i, wdata_q);

    assign bus.ready_o   = ready_s;
    assign bus.done_o    = done_q;
    assign bus.err_o     = err_q;
    assign bus.rdata_o   = rdata_q;
    assign mem_rd_addr_o = {addr_q[DEPTH-1:2], 2'b00};
    assign mem_wr_addr_o = {addr_q[DEPTH-1:2], 2'b00};

    // Next-state and memory write strobe.
    always_comb begin
        state_d       = state_q;
        mem_write_o   = 1'b0;
        mem_wr_data_o = 32'h0000_0000;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = S_ACCESS;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                state_d = S_RESP;
                if (we_q) begin
                    mem_wr_data_o = merge_s;
                    mem_write_o   = ~err_s;
                end else begin
                    mem_wr_data_o = 32'h0000_0000;
                end
            end
            S_RESP: begin
                if (accept_s) begin
                    state_d = S_ACCESS;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture on acceptance; fields hold so memory addresses stay stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= 32'h0000_0000;
        end else if (accept_s) begin
            we_q     <= bus.we_i;
            funct3_q <= bus.funct3_i;
            addr_q   <= bus.addr_i;
            wdata_q  <= bus.wdata_i;
        end
    end

    // Response registers: done pulses for one cycle, err/rdata hold until the next response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0000_0000;
        end else if (state_q == S_ACCESS) begin
            done_q  <= 1'b1;
            err_q   <= err_s;
            rdata_q <= (we_q | err_s) ? 32'h0000_0000 : load_s;
        end else begin
            done_q  <= 1'b0;
        end
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the single-cycle core's memory stage and the 32-bit data memory (read port 2 plus the write port).
- Adds byte and halfword access: LB/LH/LW/LBU/LHU/SB/SH/SW.
- Sub-word stores are done as read-modify-write, because the memory has only whole-word writes.
- Checks alignment and funct3 legality. Every request produces exactly one response.

Parameters:
DEPTH, 8, byte-address width; matches the data memory's DEPTH.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_i  in  1  request valid
we_i  in  1  1=store, 0=load
funct3_i  in  3  RISC-V funct3 of the access
addr_i  in  DEPTH  byte address
wdata_i  in  32  store data, right-aligned
ready_o  out  1  request can be accepted this cycle
done_o  out  1  one-cycle response pulse
err_o  out  1  response is an error (misaligned or illegal funct3)
rdata_o  out  32  load result, already extended
mem_rd_addr_o  out  DEPTH  to memory read port (async read)
mem_rd_data_i  in  32  from memory read port
mem_write_o  out  1  memory write enable
mem_wr_addr_o  out  DEPTH  memory write address
mem_wr_data_o  out  32  merged write word

Behaviour:
- States: IDLE, ACCESS, RESP. Reset (async, rst_n=0) forces IDLE.
- Reset values: ready_o=1, done_o=0, err_o=0, rdata_o=0, all mem_* outputs 0, request registers 0.
- ready_o=1 in IDLE and RESP; ready_o=0 in ACCESS.
- Accept: req_i&ready_o at a rising edge latches we, funct3, addr, wdata into *_q registers; state -> ACCESS.
- Unaccepted req_i is ignored; nothing is queued.
- ACCESS lasts exactly one cycle.
  - mem_rd_addr_o = mem_wr_addr_o = {addr_q[DEPTH-1:2],2'b00}; these hold in all other states.
  - Error condition, computed combinationally:
    - load funct3 not in {000,001,010,100,101}, or store funct3 not in {000,001,010};
    - H/HU with addr_q[0]=1;
    - W with addr_q[1:0]!=0.
  - Store without error: mem_write_o=1, combinational in ACCESS only; memory commits at the edge leaving ACCESS.
  - mem_wr_data_o merge rules:
    - SW: wdata_q.
    - SH: mem_rd_data_i with halfword lane addr_q[1] replaced by wdata_q[15:0].
    - SB: mem_rd_data_i with byte lane addr_q[1:0] replaced by wdata_q[7:0].
  - Load: select lane (little-endian: byte0 = bits 7:0), then sign-extend (B, H) or zero-extend (BU, HU, W passthrough).
  - At the edge leaving ACCESS, register:
    - done_o=1;
    - err_o = error;
    - rdata_o = load result, or 0 for a store or any error.
  - State -> RESP.
- RESP:
  - done_o=1 for this cycle only.
  - rdata_o/err_o hold their values until the next response is registered.
  - Next state: ACCESS if a new request is accepted, else IDLE. Sustained throughput is one access per 2 cycles.
- Latency: a request accepted at edge N gives done_o high in the cycle after edge N+1.
- Error: no write, memory unchanged, err_o=1, rdata_o=0.
- Read-after-write: a store followed by a back-to-back load to the same word returns the new data, because the write commits before the load's ACCESS.
- Reset mid-ACCESS: mem_write_o drops immediately, no write occurs, no response is generated.
- mem_write_o is never high outside ACCESS and never high for more than one cycle per request.

Test Plan:
- Memory word 0x10 = 0x8899AABB. LB @0x13 -> one done_o pulse in the cycle after ACCESS, rdata_o=0xFFFFFF88, err_o=0; mem_write_o stays 0.
- Same word:
  - LBU @0x13 -> 0x00000088;
  - LH @0x10 -> 0xFFFFAABB;
  - LHU @0x12 -> 0x00008899;
  - LW @0x10 -> 0x8899AABB.
- SB @0x11, wdata 0x12345677 -> single mem_write_o pulse, mem_wr_data_o=0x889977BB, mem_wr_addr_o=0x10. Then SH @0x12, wdata 0x0000CAFE -> word becomes 0xCAFE77BB.
- Error cases, each giving done_o=1, err_o=1, rdata_o=0, no mem_write_o, word unchanged:
  - SH @0x11;
  - LW @0x12;
  - load funct3=011;
  - store funct3=100.
- SW @0x10, 0xDEADBEEF, then LW @0x10 issued in RESP (ready_o=1) -> accepted without an idle cycle, rdata_o=0xDEADBEEF; ready_o=0 during each ACCESS.
- Assert rst_n=0 during the ACCESS of SB @0x10 -> mem_write_o falls immediately, memory unchanged, done_o=0, ready_o=1, rdata_o=0; the next LW @0x10 returns the original word.
